// File: rtl/hil_pkg.sv
// Shared types and helpers for the HIL quadrature encoder emulator.
// Pure declarations, no logic, no latency.
// No flow control; constants and a combinational helper only.
package hil_pkg;

  localparam int unsigned N_BITS_ANGLE_DEF = 16;
  localparam int unsigned CPR_LOG2_DEF     = 12;

  // Quadrature phase, value bits are {A,B}.
  typedef enum logic [1:0] {
    Q_00 = 2'b00,
    Q_10 = 2'b10,
    Q_11 = 2'b11,
    Q_01 = 2'b01
  } quad_state_t;

  // Gray-style mapping of the two count LSBs onto {A,B}; adjacent counts differ in one channel.
  function automatic quad_state_t quad_ab(input logic [1:0] cnt_lsb);
    quad_state_t ab;
    case (cnt_lsb)
      2'b00:   ab = Q_00;
      2'b01:   ab = Q_10;
      2'b10:   ab = Q_11;
      default: ab = Q_01;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/hil_encoder_emulator_if.sv
// Bundle of control inputs and encoder outputs for the emulator.
// Wires only, no latency.
// No backpressure; the emulator consumes angle every enabled cycle.
interface hil_encoder_emulator_if
  import hil_pkg::*;
#(
  parameter int unsigned N_BITS_ANGLE = N_BITS_ANGLE_DEF,
  parameter int unsigned CPR_LOG2     = CPR_LOG2_DEF
);
  logic                    en;
  logic                    clr;
  logic [N_BITS_ANGLE-1:0] angle;
  logic                    enc_a;
  logic                    enc_b;
  logic                    enc_z;
  logic [CPR_LOG2-1:0]     count;
  logic                    dir;
  logic                    busy;
  logic                    overspeed;

  // Source of angle/control, sink of encoder signals (the motor-model side / bench).
  modport master (
    output en, clr, angle,
    input  enc_a, enc_b, enc_z, count, dir, busy, overspeed
  );

  // The emulator itself.
  modport slave (
    input  en, clr, angle,
    output enc_a, enc_b, enc_z, count, dir, busy, overspeed
  );
endinterface

// File: rtl/hil_edge_timer.sv
// Minimum-spacing down-counter between encoder edges; ready when it has run out.
// load takes effect on the next edge; ready is combinational from the counter.
// en=0 freezes the counter; no other flow control.
module hil_edge_timer #(
  parameter int unsigned MIN_EDGE_CYCLES = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic load,
  output logic ready
);
  localparam int unsigned TW = (MIN_EDGE_CYCLES > 1) ? $clog2(MIN_EDGE_CYCLES) : 1;

  logic [TW-1:0] timer_q, timer_d;

  // Reload on a step, otherwise count down to zero while enabled.
  always_comb begin
    timer_d = timer_q;
    if (en) begin
      if (load) begin
        timer_d = TW'(MIN_EDGE_CYCLES - 1);
      end else if (timer_q != '0) begin
        timer_d = timer_q - TW'(1);
      end
    end
  end

  // Timer register; restarts at zero so the first step after reset is not delayed.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) timer_q <= '0;
    else       timer_q <= timer_d;
  end

  assign ready = (timer_q == '0);
endmodule

// File: rtl/hil_encoder_emulator.sv
// Turns the motor-model angle into rate-limited quadrature A/B/Z with a sticky lag fault.
// angle -> first edge 2 clk (target register, then step) when the edge timer is idle.
// No backpressure; at most one count per MIN_EDGE_CYCLES, excess motion accumulates as lag.
module hil_encoder_emulator
  import hil_pkg::*;
#(
  parameter int unsigned N_BITS_ANGLE    = N_BITS_ANGLE_DEF,
  parameter int unsigned CPR_LOG2        = CPR_LOG2_DEF,
  parameter int unsigned MIN_EDGE_CYCLES = 4,
  parameter int unsigned MAX_LAG         = 64,
  parameter int unsigned Z_COUNTS        = 1
) (
  input logic                   clk,
  input logic                   nrst,
  hil_encoder_emulator_if.slave bus
);
  localparam logic [CPR_LOG2-1:0] HALF = {1'b1, {(CPR_LOG2-1){1'b0}}};
  localparam logic [CPR_LOG2-1:0] ONE  = {{(CPR_LOG2-1){1'b0}}, 1'b1};

  logic [CPR_LOG2-1:0] target_q, target_d;
  logic [CPR_LOG2-1:0] count_q, count_d;
  logic                dir_q, dir_d;
  logic                enc_a_q, enc_a_d;
  logic                enc_b_q, enc_b_d;
  logic                enc_z_q, enc_z_d;
  logic                busy_q, busy_d;
  logic                ovs_q, ovs_d;

  logic [CPR_LOG2-1:0] diff;
  logic [CPR_LOG2-1:0] abs_diff;
  logic                step_fwd;
  logic                step;
  logic                timer_ready;
  quad_state_t         ab_d;

  // Angle bits below one count are truncated away.
  logic unused_angle_lsbs;
  assign unused_angle_lsbs = ^bus.angle[N_BITS_ANGLE-CPR_LOG2-1:0];

  hil_edge_timer #(
    .MIN_EDGE_CYCLES(MIN_EDGE_CYCLES)
  ) u_edge_timer (
    .clk  (clk),
    .nrst (nrst),
    .en   (bus.en),
    .load (step),
    .ready(timer_ready)
  );

  // Shortest-path direction toward the target, step decision, and next register values.
  always_comb begin
    target_d = target_q;
    count_d  = count_q;
    dir_d    = dir_q;
    busy_d   = busy_q;
    ovs_d    = ovs_q;

    diff     = target_q - count_q;
    // Half-revolution tie goes forward; two's-complement negation of HALF is HALF itself.
    step_fwd = !diff[CPR_LOG2-1] || (diff == HALF);
    abs_diff = diff[CPR_LOG2-1] ? -diff : diff;
    step     = bus.en && timer_ready && (diff != '0);

    if (bus.en) begin
      target_d = bus.angle[N_BITS_ANGLE-1 -: CPR_LOG2];
      busy_d   = 1'b0;
    end
    if (step) begin
      count_d = step_fwd ? (count_q + ONE) : (count_q - ONE);
      dir_d   = step_fwd;
    end
    if (bus.en) begin
      busy_d = (target_d != count_d);
    end

    ab_d               = quad_ab(count_d[1:0]);
    {enc_a_d, enc_b_d} = ab_d;
    enc_z_d            = (count_d < CPR_LOG2'(Z_COUNTS));

    // Clear first so a simultaneous set condition wins.
    if (bus.clr) ovs_d = 1'b0;
    if (bus.en && (abs_diff > CPR_LOG2'(MAX_LAG))) ovs_d = 1'b1;
  end

  // State and output registers; en=0 leaves every _d equal to its _q except the fault clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      target_q <= '0;
      count_q  <= '0;
      dir_q    <= 1'b0;
      enc_a_q  <= 1'b0;
      enc_b_q  <= 1'b0;
      enc_z_q  <= 1'b1;
      busy_q   <= 1'b0;
      ovs_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      enc_a_q  <= enc_a_d;
      enc_b_q  <= enc_b_d;
      enc_z_q  <= enc_z_d;
      busy_q   <= busy_d;
      ovs_q    <= ovs_d;
    end
  end

  assign bus.enc_a     = enc_a_q;
  assign bus.enc_b     = enc_b_q;
  assign bus.enc_z     = enc_z_q;
  assign bus.count     = count_q;
  assign bus.dir       = dir_q;
  assign bus.busy      = busy_q;
  assign bus.overspeed = ovs_q;
endmodule
